// File: rtl/reg_bank_param.sv
// Parametrised 2-read/1-write register bank with optional zero register and a bulk-clear sweep.
// Optional macro REG_BANK_BYPASS_EN enables same-cycle write-to-read forwarding.
module reg_bank_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              clr_req,
  output logic              busy
);

  localparam int unsigned Depth  = 2 ** ADDR_W;
  localparam bit          ZeroEn = (ZERO_REG != 0);

  typedef enum logic [0:0] {
    StIdle,
    StClear
  } state_e;

  state_e              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_busy;
  logic [DATA_W-1:0]   r_bank [Depth];

  logic                w_wr_commit;
  logic                w_cnt_last;
  logic [DATA_W-1:0]   w_rd1;
  logic [DATA_W-1:0]   w_rd2;

  assign w_wr_commit = we && (r_state == StIdle) && !(ZeroEn && (wa == '0));
  assign w_cnt_last  = (r_cnt == {ADDR_W{1'b1}});

  // Clear FSM: busy is registered so it tracks the state exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (clr_req) begin
            r_state <= StClear;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        StClear: begin
          if (w_cnt_last) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // A write on the edge that starts a sweep still lands; the sweep zeroes it later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(Depth); i++) begin
        r_bank[i] <= '0;
      end
    end else if (r_state == StClear) begin
      r_bank[r_cnt] <= '0;
    end else if (w_wr_commit) begin
      r_bank[wa] <= wd;
    end
  end

  always_comb begin
    w_rd1 = r_bank[ra1];
    w_rd2 = r_bank[ra2];
`ifdef REG_BANK_BYPASS_EN
    if (w_wr_commit && (ra1 == wa)) begin
      w_rd1 = wd;
    end
    if (w_wr_commit && (ra2 == wa)) begin
      w_rd2 = wd;
    end
`else
`endif
    if (ZeroEn && (ra1 == '0)) begin
      w_rd1 = '0;
    end
    if (ZeroEn && (ra2 == '0)) begin
      w_rd2 = '0;
    end
  end

  assign rd1  = w_rd1;
  assign rd2  = w_rd2;
  assign busy = r_busy;

endmodule

// File: tb/tb_reg_bank_param.sv
// Directed self-checking bench for reg_bank_param (ZERO_REG=1 and ZERO_REG=0 instances).
module tb_reg_bank_param;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic        clr_req;
  logic [31:0] rd1, rd2, nz_rd1, nz_rd2;
  logic        busy, nz_busy;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef REG_BANK_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  reg_bank_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .ra1(ra1), .ra2(ra2),
    .rd1(rd1), .rd2(rd2), .clr_req(clr_req), .busy(busy)
  );

  reg_bank_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .ra1(ra1), .ra2(ra2),
    .rd1(nz_rd1), .rd2(nz_rd2), .clr_req(clr_req), .busy(nz_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; wa = a; wd = d;
    tick();
    we = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i);
      #1;
      check({tag, "_rd1"}, rd1, 32'h0);
      check({tag, "_rd2"}, rd2, 32'h0);
      check({tag, "_nz_rd1"}, nz_rd1, 32'h0);
    end
  endtask

  int n;

  initial begin
    rst_n = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0; clr_req = 1'b0;
    tick();
    wr(5'd5, 32'h55);
    wr(5'd31, 32'h31);
    ra1 = 5'd5; ra2 = 5'd31;
    #1;
    check("pre_reset_rd1", rd1, 32'h55);
    // 1. Asynchronous reset mid-run
    #1 rst_n = 1'b0;
    #1;
    check("reset_rd1", rd1, 32'h0);
    check("reset_rd2", rd2, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 2. Write then read
    we = 1'b1; wa = 5'd3; wd = 32'hDEADBEEF; ra1 = 5'd3;
    #1;
    check("wr_same_cycle", rd1, Bypass ? 32'hDEADBEEF : 32'h0);
    tick();
    we = 1'b0;
    #1;
    check("wr_after_edge", rd1, 32'hDEADBEEF);

    // 3. Zero register
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra1 = 5'd0;
    #1;
    check("zero_same_cycle", rd1, 32'h0);
    check("nz_zero_same_cycle", nz_rd1, Bypass ? 32'hFFFFFFFF : 32'h0);
    tick();
    we = 1'b0;
    #1;
    check("zero_after_edge", rd1, 32'h0);
    check("nz_zero_after_edge", nz_rd1, 32'hFFFFFFFF);

    // 6. Dual-port collision
    wr(5'd12, 32'hAAAA);
    we = 1'b1; wa = 5'd12; wd = 32'h1234; ra1 = 5'd12; ra2 = 5'd12;
    #1;
    check("coll_rd1", rd1, Bypass ? 32'h1234 : 32'hAAAA);
    check("coll_rd2", rd2, Bypass ? 32'h1234 : 32'hAAAA);
    tick();
    we = 1'b0;
    #1;
    check("coll_after_rd1", rd1, 32'h1234);
    check("coll_after_rd2", rd2, 32'h1234);

    // 4. Clear sweep
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
    ra1 = 5'd7; ra2 = 5'd20;
    #1;
    check("fill_rd1", rd1, 32'd7);
    check("fill_rd2", rd2, 32'd20);
    clr_req = 1'b1; we = 1'b1; wa = 5'd20; wd = 32'h55;
    tick();
    clr_req = 1'b0; we = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      if (n == 10) begin
        ra1 = 5'd3; ra2 = 5'd20;
        #1;
        check("sweep_low_cleared", rd1, 32'h0);
        check("sweep_start_write", rd2, 32'h55);
        we = 1'b1; wa = 5'd7; wd = 32'd9; ra1 = 5'd7;
        #1;
        check("sweep_no_bypass", rd1, 32'h0);
        clr_req = 1'b1;
      end
      tick();
      we = 1'b0; clr_req = 1'b0;
      n++;
    end
    check("sweep_busy_cycles", 32'(n), 32'd32);
    check_all_zero("after_sweep");

    // 5. Reset mid-sweep, then a fresh sweep
    wr(5'd5, 32'h5);
    wr(5'd31, 32'h31);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("mid_busy_before", {31'h0, busy}, 32'h1);
    ra1 = 5'd31; ra2 = 5'd5;
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_rd1", rd1, 32'h0);
    tick();
    rst_n = 1'b1;
    check_all_zero("after_mid_rst");
    wr(5'd2, 32'h22);
    wr(5'd30, 32'h30);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      if (n == 3) begin
        ra1 = 5'd2; ra2 = 5'd30;
        #1;
        check("fresh_low_cleared", rd1, 32'h0);
        check("fresh_high_kept", rd2, 32'h30);
      end
      tick();
      n++;
    end
    check("fresh_busy_cycles", 32'(n), 32'd32);
    ra2 = 5'd30;
    #1;
    check("fresh_done_rd2", rd2, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
